// File: rtl/inst_queue.sv
// Instruction queue: sequential fetch FSM feeding a PC-tagged FIFO that the decoder drains.
// Optional feature macro: IQ_JAL_PREDICT_EN (static jal target prediction on push).
module inst_queue #(
    parameter int          DEPTH_LOG = 4,
    parameter logic [31:0] RST_PC    = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic [31:0] clear_pc,
    output logic        fetch_req,
    output logic [31:0] fetch_pc,
    input  logic        fetch_done,
    input  logic [31:0] fetch_inst,
    input  logic        Get_Inst,
    output logic        en_out,
    output logic [31:0] Inst_out,
    output logic [31:0] pc_out,
    output logic        IQ_isempty,
    output logic        IQ_isfull
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam int CNT_W = DEPTH_LOG + 1;
    localparam logic [DEPTH_LOG-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0]     CNT_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    logic [63:0]          mem_r [DEPTH];
    logic [DEPTH_LOG-1:0] head_r;
    logic [DEPTH_LOG-1:0] tail_r;
    logic [CNT_W-1:0]     count_r;
    state_t               state_r;
    state_t               state_nxt_s;
    logic                 req_nxt_s;
    logic [31:0]          pc_nxt_s;
    logic [31:0]          pc_step_s;
    logic                 push_s;
    logic                 pop_s;

    assign IQ_isempty = (count_r == {CNT_W{1'b0}});
    assign IQ_isfull  = (count_r == CNT_W'(DEPTH));
    assign pop_s      = rdy_in && Get_Inst && !IQ_isempty && !clear;

    // PC advance after a push: +4, or the jal target when prediction is built in
    always_comb begin
        pc_step_s = 32'd4;
`ifdef IQ_JAL_PREDICT_EN
        if (fetch_inst[6:0] == 7'b1101111) begin
            pc_step_s = {{11{fetch_inst[31]}}, fetch_inst[31], fetch_inst[19:12],
                         fetch_inst[20], fetch_inst[30:21], 1'b0};
        end else begin
            pc_step_s = 32'd4;
        end
`endif
    end

    // Fetch FSM next-state; clear overrides everything and drops any same-cycle response
    always_comb begin
        state_nxt_s = state_r;
        req_nxt_s   = fetch_req;
        pc_nxt_s    = fetch_pc;
        push_s      = 1'b0;
        if (clear) begin
            pc_nxt_s  = clear_pc;
            req_nxt_s = 1'b0;
            case (state_r)
                ST_WAIT:    state_nxt_s = fetch_done ? ST_IDLE : ST_DISCARD;
                ST_DISCARD: state_nxt_s = fetch_done ? ST_IDLE : ST_DISCARD;
                default:    state_nxt_s = ST_IDLE;
            endcase
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rdy_in && !IQ_isfull) begin
                        req_nxt_s   = 1'b1;
                        state_nxt_s = ST_WAIT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (fetch_done) begin
                        push_s      = 1'b1;
                        pc_nxt_s    = fetch_pc + pc_step_s;
                        req_nxt_s   = 1'b0;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_DISCARD: begin
                    if (fetch_done) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DISCARD;
                    end
                end
                default: begin
                    req_nxt_s   = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Fetch FSM state, request and PC registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r   <= ST_IDLE;
            fetch_req <= 1'b0;
            fetch_pc  <= RST_PC;
        end else begin
            state_r   <= state_nxt_s;
            fetch_req <= req_nxt_s;
            fetch_pc  <= pc_nxt_s;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_r  <= {DEPTH_LOG{1'b0}};
            tail_r  <= {DEPTH_LOG{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            head_r  <= {DEPTH_LOG{1'b0}};
            tail_r  <= {DEPTH_LOG{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) tail_r <= tail_r + PTR_ONE;
            if (pop_s)  head_r <= head_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk_in) begin
        if (push_s) mem_r[tail_r] <= {fetch_pc, fetch_inst};
    end

    // Registered pop port toward the decoder
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            en_out   <= 1'b0;
            Inst_out <= 32'h0000_0000;
            pc_out   <= 32'h0000_0000;
        end else begin
            en_out <= pop_s;
            if (pop_s) {pc_out, Inst_out} <= mem_r[head_r];
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: bench-driven fetch responses, hand-computed expectations.
// Honours IQ_JAL_PREDICT_EN to select the expected post-jal fetch address.
module tb_inst_queue;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        clear = 1'b0;
    logic [31:0] clear_pc = 32'h0;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_done = 1'b0;
    logic [31:0] fetch_inst = 32'h0;
    logic        Get_Inst = 1'b0;
    logic        en_out;
    logic [31:0] Inst_out;
    logic [31:0] pc_out;
    logic        IQ_isempty;
    logic        IQ_isfull;

    int vectors = 0;
    int miscompares = 0;

`ifdef IQ_JAL_PREDICT_EN
    localparam logic [31:0] JAL_NEXT = 32'h0000_0030;
`else
    localparam logic [31:0] JAL_NEXT = 32'h0000_0014;
`endif
    localparam logic [31:0] JAL_INST = 32'h0200_006F;

    inst_queue #(.DEPTH_LOG(4), .RST_PC(32'h0)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .clear_pc(clear_pc), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .fetch_done(fetch_done), .fetch_inst(fetch_inst), .Get_Inst(Get_Inst),
        .en_out(en_out), .Inst_out(Inst_out), .pc_out(pc_out),
        .IQ_isempty(IQ_isempty), .IQ_isfull(IQ_isfull)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mk(input logic [31:0] pc);
        return 32'h0000_0013 | (pc << 8);
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (fetch_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("req_issue", {31'b0, fetch_req}, 32'd1);
    endtask

    task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] inst, input int lat);
        wait_req();
        check("fetch_pc", fetch_pc, exp_pc);
        repeat (lat - 1) tick();
        fetch_done = 1'b1;
        fetch_inst = inst;
        tick();
        fetch_done = 1'b0;
        check("req_drop", {31'b0, fetch_req}, 32'd0);
    endtask

    task automatic expect_pop(input logic [31:0] pc, input logic [31:0] inst);
        check("en_out", {31'b0, en_out}, 32'd1);
        check("pc_out", pc_out, pc);
        check("inst_out", Inst_out, inst);
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        check("rst_req", {31'b0, fetch_req}, 32'd0);
        check("rst_pc", fetch_pc, 32'h0);
        check("rst_en", {31'b0, en_out}, 32'd0);
        check("rst_inst", Inst_out, 32'h0);
        check("rst_pcout", pc_out, 32'h0);
        check("rst_empty", {31'b0, IQ_isempty}, 32'd1);
        check("rst_full", {31'b0, IQ_isfull}, 32'd0);
        rst_in = 1'b0;

        // sequential fetch, fill to 16 entries
        fetch(32'h0, mk(32'h0), 4);
        check("empty_fall", {31'b0, IQ_isempty}, 32'd0);
        for (int i = 1; i < 16; i++) fetch(32'(i * 4), mk(32'(i * 4)), 4);
        check("full", {31'b0, IQ_isfull}, 32'd1);
        repeat (3) tick();
        check("full_noreq", {31'b0, fetch_req}, 32'd0);

        // one pop frees a slot, fetch resumes at 0x40
        Get_Inst = 1'b1;
        tick();
        Get_Inst = 1'b0;
        expect_pop(32'h0, mk(32'h0));
        check("unfull", {31'b0, IQ_isfull}, 32'd0);
        fetch(32'h40, mk(32'h40), 2);
        check("refull", {31'b0, IQ_isfull}, 32'd1);

        // drain across the 15->0 wrap, then no underflow
        Get_Inst = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            expect_pop(32'(i * 4), mk(32'(i * 4)));
        end
        tick();
        check("drain_en0", {31'b0, en_out}, 32'd0);
        check("drain_empty", {31'b0, IQ_isempty}, 32'd1);
        tick();
        check("underflow_en0", {31'b0, en_out}, 32'd0);
        Get_Inst = 1'b0;
        check("wait_req", {31'b0, fetch_req}, 32'd1);
        check("wait_pc", fetch_pc, 32'h44);

        // clear in WAIT, stale response dropped
        clear = 1'b1;
        clear_pc = 32'h1000;
        tick();
        clear = 1'b0;
        check("clr_req", {31'b0, fetch_req}, 32'd0);
        check("clr_pc", fetch_pc, 32'h1000);
        check("clr_empty", {31'b0, IQ_isempty}, 32'd1);
        tick();
        check("discard_noreq", {31'b0, fetch_req}, 32'd0);
        fetch_done = 1'b1;
        fetch_inst = 32'hDEAD_BEEF;
        tick();
        fetch_done = 1'b0;
        check("stale_dropped", {31'b0, IQ_isempty}, 32'd1);
        for (int i = 0; i < 5; i++) fetch(32'h1000 + 32'(i * 4), mk(32'h1000 + 32'(i * 4)), 2);

        // same-edge push and pop at count 5
        wait_req();
        check("pp_pc", fetch_pc, 32'h1014);
        fetch_done = 1'b1;
        fetch_inst = mk(32'h1014);
        Get_Inst = 1'b1;
        tick();
        fetch_done = 1'b0;
        expect_pop(32'h1000, mk(32'h1000));
        for (int i = 1; i <= 5; i++) begin
            tick();
            expect_pop(32'h1000 + 32'(i * 4), mk(32'h1000 + 32'(i * 4)));
        end
        tick();
        check("pp_en0", {31'b0, en_out}, 32'd0);
        check("pp_empty", {31'b0, IQ_isempty}, 32'd1);
        Get_Inst = 1'b0;

        // mid-run async reset, then jal at 0x10
        rst_in = 1'b1;
        #1;
        check("arst_req", {31'b0, fetch_req}, 32'd0);
        check("arst_pc", fetch_pc, 32'h0);
        tick();
        rst_in = 1'b0;
        for (int i = 0; i < 4; i++) fetch(32'(i * 4), mk(32'(i * 4)), 1);
        fetch(32'h10, JAL_INST, 3);
        wait_req();
        check("jal_next_pc", fetch_pc, JAL_NEXT);

        // rdy_in low: no pops, no new requests, but the response is still captured
        rdy_in = 1'b0;
        Get_Inst = 1'b1;
        fetch_done = 1'b1;
        fetch_inst = mk(JAL_NEXT);
        tick();
        fetch_done = 1'b0;
        check("frz_en0", {31'b0, en_out}, 32'd0);
        check("frz_req0", {31'b0, fetch_req}, 32'd0);
        tick();
        check("frz_noreq", {31'b0, fetch_req}, 32'd0);
        check("frz_en0b", {31'b0, en_out}, 32'd0);
        rdy_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_pop(32'(i * 4), mk(32'(i * 4)));
        end
        tick();
        expect_pop(32'h10, JAL_INST);
        tick();
        expect_pop(JAL_NEXT, mk(JAL_NEXT));
        Get_Inst = 1'b0;
        tick();
        check("end_en0", {31'b0, en_out}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
